// File: rtl/demod_decim.sv
// Decimating boxcar low-pass for the demodulator output stream.
// Averages 2^LOG2_DEC strobed samples and presents one result on a valid/ready port.
module demod_decim #(
    parameter int WIDTH    = 16,
    parameter int LOG2_DEC = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic signed [WIDTH-1:0] demod_i,
    input  logic                    ready_i,
    output logic signed [WIDTH-1:0] audio_o,
    output logic                    valid_o,
    output logic                    ovf_o
);

    localparam int AW = WIDTH + LOG2_DEC;
    localparam int CW = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_DEC) - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t                  state_reg, state_next;
    logic signed [AW-1:0]    acc_reg, acc_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic signed [WIDTH-1:0] audio_reg, audio_next;
    logic                    ovf_reg, ovf_next;
    logic signed [AW-1:0]    sample_ext;
    logic signed [AW-1:0]    sum;
    logic                    dump;

    // Accumulator is wide enough that DEC full-scale samples can never wrap.
    assign sample_ext[WIDTH-1:0] = demod_i;
    generate
        for (genvar gi = 0; gi < LOG2_DEC; gi++) begin : g_sext
            assign sample_ext[WIDTH+gi] = demod_i[WIDTH-1];
        end
    endgenerate

    assign sum  = acc_reg + sample_ext;
    assign dump = en_i && !clr_i && (cnt_reg == CNT_LAST);

    always_comb begin
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        audio_next = audio_reg;
        if (clr_i) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (en_i) begin
            if (dump) begin
                acc_next   = '0;
                cnt_next   = '0;
                // Dropping the low bits is an arithmetic shift with floor rounding.
                audio_next = sum[AW-1:LOG2_DEC];
            end else begin
                acc_next = sum;
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            EMPTY: begin
                if (dump) state_next = FULL;
            end
            FULL: begin
                if (dump) begin
                    if (!ready_i) ovf_next = 1'b1;
                end else if (ready_i) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= EMPTY;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            audio_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            audio_reg <= audio_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign audio_o = audio_reg;
    assign valid_o = (state_reg == FULL);
    assign ovf_o   = ovf_reg;

endmodule

// File: tb/tb_demod_decim.sv
// Directed bench for demod_decim: expected results are queued by the stimulus
// and a monitor compares every accepted output transfer against the queue.
module tb_demod_decim;

    logic               clk;
    logic               rst;
    logic               en_i;
    logic               clr_i;
    logic signed [15:0] demod_i;
    logic               ready_i;
    logic signed [15:0] audio_o;
    logic               valid_o;
    logic               ovf_o;

    typedef struct packed {
        logic signed [15:0] audio;
        logic               ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    demod_decim #(.WIDTH(16), .LOG2_DEC(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en_i),
        .clr_i   (clr_i),
        .demod_i (demod_i),
        .ready_i (ready_i),
        .audio_o (audio_o),
        .valid_o (valid_o),
        .ovf_o   (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic send(input int v);
        en_i    = 1'b1;
        demod_i = 16'(v);
        @(posedge clk);
        #1;
        en_i = 1'b0;
    endtask

    task automatic send_n(input int v, input int n);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic push(input int a, input logic o);
        exp_t e;
        e.audio = 16'(a);
        e.ovf   = o;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per accepted transfer (valid and ready before the edge).
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && valid_o && ready_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL xfer: unexpected audio_o=%0d ovf_o=%0d, nothing queued",
                             audio_o, ovf_o);
                end else begin
                    e = exp_q.pop_front();
                    if (audio_o !== e.audio || ovf_o !== e.ovf) begin
                        bad++;
                        $display("FAIL xfer: got audio_o=%0d ovf_o=%0d expected audio_o=%0d ovf_o=%0d",
                                 audio_o, ovf_o, e.audio, e.ovf);
                    end else begin
                        $display("ok   xfer: audio_o=%0d ovf_o=%0d", audio_o, ovf_o);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        en_i    = 1'b0;
        clr_i   = 1'b0;
        demod_i = '0;
        ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset audio_o", int'(audio_o), 0);
        chk("reset valid_o", int'(valid_o), 0);
        chk("reset ovf_o", int'(ovf_o), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Constant window
        push(100, 1'b0);
        send_n(100, 8);

        // Ramp 1..8: sum 36, floor(36/8)=4
        push(4, 1'b0);
        for (int i = 1; i <= 8; i++) send(i);

        // Floor rounding of a negative mean: -1/8 -> -1
        push(-1, 1'b0);
        send(-1);
        send_n(0, 7);

        // Full-scale extremes, no wrap
        push(-32768, 1'b0);
        send_n(-32768, 8);
        push(32767, 1'b0);
        send_n(32767, 8);
        repeat (2) @(posedge clk);
        #1;
        chk("idle valid_o after drain", int'(valid_o), 0);
        chk("audio_o held while empty", int'($signed(audio_o)), 32767);

        // Dump while FULL with ready high: old result accepted, new one replaces it
        ready_i = 1'b0;
        push(50, 1'b0);
        push(60, 1'b0);
        send_n(50, 8);
        send_n(60, 7);
        chk("full hold valid_o", int'(valid_o), 1);
        chk("full hold audio_o", int'($signed(audio_o)), 50);
        ready_i = 1'b1;
        send(60);
        chk("simul dump valid_o", int'(valid_o), 1);
        chk("simul dump audio_o", int'($signed(audio_o)), 60);
        chk("simul dump ovf_o", int'(ovf_o), 0);
        @(posedge clk);
        #1;

        // Backpressure: second window overwrites the first
        ready_i = 1'b0;
        send_n(10, 8);
        send_n(20, 8);
        chk("backpressure valid_o", int'(valid_o), 1);
        chk("backpressure audio_o", int'($signed(audio_o)), 20);
        chk("backpressure ovf_o", int'(ovf_o), 1);
        push(20, 1'b1);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("after accept valid_o", int'(valid_o), 0);
        chk("ovf_o sticky", int'(ovf_o), 1);

        // Async reset mid-window discards the partial sum
        send_n(1000, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst audio_o", int'($signed(audio_o)), 0);
        chk("async rst valid_o", int'(valid_o), 0);
        chk("async rst ovf_o", int'(ovf_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(10, 1'b0);
        send_n(10, 8);
        @(posedge clk);
        #1;

        // clr_i together with a strobe: strobe and partial sum both dropped
        send_n(1000, 5);
        clr_i = 1'b1;
        send(1000);
        clr_i = 1'b0;
        chk("clr keeps valid_o", int'(valid_o), 0);
        push(10, 1'b0);
        send_n(10, 8);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results never appeared, expected 0 pending", exp_q.size());
        end
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
